// File: rtl/dcache_mem_initiator_pkg.sv
// Shared memory-port encodings for the data-cache memory initiator.
// Command, status and access-size codes driven to and decoded from main memory.
package dcache_mem_initiator_pkg;

  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  localparam logic [1:0] MEM_RESTING       = 2'd0;
  localparam logic [1:0] MEM_DATA_FINISHED = 2'd1;
  localparam logic [1:0] MEM_INST_FINISHED = 2'd2;

  localparam logic [2:0] ONE_BYTE   = 3'd0;
  localparam logic [2:0] TWO_BYTE   = 3'd1;
  localparam logic [2:0] FOUR_BYTE  = 3'd2;
  localparam logic [2:0] EIGHT_BYTE = 3'd3;

endpackage

// File: rtl/dcache_mem_initiator.sv
// Splits one cache-line fill or writeback into fully handshaken 4-byte memory beats
// and assembles read beats into a line.
module dcache_mem_initiator
  import dcache_mem_initiator_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 17,
  parameter int unsigned DATA_LEN         = 32,
  parameter int unsigned LINE_WORDS       = 4,
  parameter int unsigned ENTRY_INDEX_SIZE = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [LINE_WORDS*DATA_LEN-1:0] req_wdata,
  output logic                           resp_valid,
  output logic [LINE_WORDS*DATA_LEN-1:0] resp_rdata,
  output logic [1:0]                     d_cache_mem_vis_signal,
  output logic [ADDR_WIDTH-1:0]          d_cache_mem_vis_addr,
  output logic [DATA_LEN-1:0]            written_data,
  output logic [2:0]                     data_type,
  output logic [ENTRY_INDEX_SIZE:0]      length,
  input  logic [DATA_LEN-1:0]            mem_data,
  input  logic [1:0]                     mem_status
);

  localparam int unsigned LineBytesLog2 = $clog2(LINE_WORDS * 4);
  localparam int unsigned BeatW         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned LenW          = ENTRY_INDEX_SIZE + 1;
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ~ADDR_WIDTH'((64'd1 << LineBytesLog2) - 64'd1);
  localparam logic [BeatW-1:0]      LastBeat  = BeatW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap,
    StDone
  } state_e;

  state_e                         state_q;
  logic [BeatW-1:0]               beat_q;
  logic [BeatW-1:0]               next_beat;
  logic                           write_q;
  logic [LINE_WORDS*DATA_LEN-1:0] wline_q;
  logic [LINE_WORDS*DATA_LEN-1:0] line_q;

  assign req_ready = (state_q == StIdle);
  assign data_type = FOUR_BYTE;
  assign length    = LenW'(LINE_WORDS);
  assign next_beat = beat_q + BeatW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                <= StIdle;
      beat_q                 <= '0;
      write_q                <= 1'b0;
      wline_q                <= '0;
      line_q                 <= '0;
      d_cache_mem_vis_signal <= MEM_NOP;
      d_cache_mem_vis_addr   <= '0;
      written_data           <= '0;
      resp_valid             <= 1'b0;
      resp_rdata             <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q                <= req_write;
            wline_q                <= req_wdata;
            beat_q                 <= '0;
            d_cache_mem_vis_addr   <= req_addr & AlignMask;
            written_data           <= req_wdata[DATA_LEN-1:0];
            d_cache_mem_vis_signal <= req_write ? MEM_WRITE : MEM_READ;
            state_q                <= StIssue;
          end
        end
        StIssue: begin
          // Instruction-side completions and resting status leave the beat pending.
          if (mem_status == MEM_DATA_FINISHED) begin
            if (!write_q) begin
              line_q[int'(beat_q) * DATA_LEN +: DATA_LEN] <= mem_data;
            end
            d_cache_mem_vis_signal <= MEM_NOP;
            state_q                <= StGap;
          end
        end
        StGap: begin
          if (mem_status == MEM_RESTING) begin
            if (beat_q == LastBeat) begin
              resp_valid <= 1'b1;
              if (!write_q) begin
                resp_rdata <= line_q;
              end
              state_q <= StDone;
            end else begin
              beat_q                 <= next_beat;
              d_cache_mem_vis_addr   <= d_cache_mem_vis_addr + ADDR_WIDTH'(4);
              written_data           <= wline_q[int'(next_beat) * DATA_LEN +: DATA_LEN];
              d_cache_mem_vis_signal <= write_q ? MEM_WRITE : MEM_READ;
              state_q                <= StIssue;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_mem_initiator.sv
// Self-checking bench: behavioural memory with I-cache priority, beat and response scoreboards.
module tb_dcache_mem_initiator;
  import dcache_mem_initiator_pkg::*;

  localparam int AW = 17;
  localparam int DL = 32;
  localparam int LW = 4;
  localparam int LINEW = LW * DL;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_write = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [LINEW-1:0] req_wdata = '0;
  logic             resp_valid;
  logic [LINEW-1:0] resp_rdata;
  logic [1:0]       dsig;
  logic [AW-1:0]    daddr;
  logic [DL-1:0]    written_data;
  logic [2:0]       data_type;
  logic [3:0]       length;
  logic [DL-1:0]    mem_data = '0;
  logic [1:0]       mem_status = MEM_RESTING;
  logic [1:0]       ic_sig = MEM_NOP;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  dcache_mem_initiator dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_write              (req_write),
    .req_addr               (req_addr),
    .req_wdata              (req_wdata),
    .resp_valid             (resp_valid),
    .resp_rdata             (resp_rdata),
    .d_cache_mem_vis_signal (dsig),
    .d_cache_mem_vis_addr   (daddr),
    .written_data           (written_data),
    .data_type              (data_type),
    .length                 (length),
    .mem_data               (mem_data),
    .mem_status             (mem_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-addressed memory; I-cache reads win arbitration when the port is resting.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    case (mem_status)
      MEM_RESTING: begin
        if (ic_sig == MEM_READ) begin
          mem_status <= MEM_INST_FINISHED;
        end else if (dsig == MEM_READ) begin
          mem_data   <= {mem[daddr], mem[AW'(daddr + 1)], mem[AW'(daddr + 2)], mem[AW'(daddr + 3)]};
          mem_status <= MEM_DATA_FINISHED;
        end else if (dsig == MEM_WRITE) begin
          mem[daddr]         <= written_data[31:24];
          mem[AW'(daddr + 1)] <= written_data[23:16];
          mem[AW'(daddr + 2)] <= written_data[15:8];
          mem[AW'(daddr + 3)] <= written_data[7:0];
          mem_status <= MEM_DATA_FINISHED;
        end
      end
      MEM_INST_FINISHED: if (ic_sig == MEM_NOP) mem_status <= MEM_RESTING;
      MEM_DATA_FINISHED: if (dsig == MEM_NOP) mem_status <= MEM_RESTING;
      default: mem_status <= MEM_RESTING;
    endcase
  end

  typedef struct {
    logic [1:0]    sig;
    logic [AW-1:0] addr;
    logic [DL-1:0] wdata;
    logic [2:0]    dt;
    int            nop_run;
    bit            has_x;
  } beat_t;

  typedef struct {
    logic [LINEW-1:0] line;
    int               cyc;
  } resp_t;

  beat_t            obs_q[$];
  beat_t            exp_q[$];
  resp_t            resp_q[$];
  logic [LINEW-1:0] exp_resp_q[$];
  logic [LINEW-1:0] last_fill = '0;
  int               e0;

  logic [1:0] prev_sig = MEM_NOP;
  int         nop_run = 100;
  always @(negedge clk) begin
    if (dsig != MEM_NOP && prev_sig == MEM_NOP) begin
      obs_q.push_back('{dsig, daddr, written_data, data_type, nop_run,
                        $isunknown({dsig, daddr, written_data, resp_valid, resp_rdata})});
    end
    if (dsig == MEM_NOP) nop_run <= nop_run + 1;
    else nop_run <= 0;
    prev_sig <= dsig;
    if (resp_valid) resp_q.push_back('{resp_rdata, cyc});
  end

  function automatic logic [LINEW-1:0] line_at(input logic [AW-1:0] base);
    logic [LINEW-1:0] l;
    logic [AW-1:0]    a;
    l = '0;
    for (int w = 0; w < LW; w++) begin
      for (int b = 0; b < 4; b++) begin
        a = AW'(base + AW'(4 * w + b));
        l[w*DL + (3-b)*8 +: 8] = mem[a];
      end
    end
    return l;
  endfunction

  // Drives one request and records what the DUT should do with it.
  task automatic start_op(input bit wr, input logic [AW-1:0] addr, input logic [LINEW-1:0] wd,
                          input bit hold);
    logic [AW-1:0] base;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    base = addr & ~AW'(15);
    for (int b = 0; b < LW; b++) begin
      exp_q.push_back('{wr ? MEM_WRITE : MEM_READ, AW'(base + AW'(4 * b)), wd[b*DL +: DL],
                        FOUR_BYTE, 0, 1'b0});
    end
    if (!wr) last_fill = line_at(base);
    exp_resp_q.push_back(last_fill);
    @(posedge clk);
    #1;
    e0 = cyc;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n, output bit ok);
    int guard;
    guard = 0;
    while (resp_q.size() < n && guard < 400) begin
      @(negedge clk);
      #1;
      guard++;
    end
    ok = (resp_q.size() >= n);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    tests_run++;
    if (dsig !== MEM_NOP || daddr !== '0 || written_data !== '0 || resp_valid !== 1'b0 ||
        resp_rdata !== '0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: got sig=%h addr=%h wd=%h rv=%b rdy=%b expected 0/0/0/0/1",
               dsig, daddr, written_data, resp_valid, req_ready);
    end
    tests_run++;
    if (data_type !== FOUR_BYTE || length !== 4'd4) begin
      tests_failed++;
      $display("FAIL const_outputs: got dt=%h len=%h expected %h/4", data_type, length, FOUR_BYTE);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    bit ok;
    beat_t o, e;
    resp_t r;
    logic [LINEW-1:0] el;
    for (int i = 0; i < 16; i++) mem[AW'(32'h100 + i)] = (i == 15) ? 8'h00 : 8'((i + 1) * 17);
    start_op(1'b0, AW'(32'h104), '0, 1'b0);
    wait_resp(1, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL fill_timeout: got no resp_valid expected one");
      return;
    end
    for (int b = 0; b < LW; b++) begin
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++;
        $display("FAIL fill_beat%0d: got no beat expected addr %h", b, exp_q[0].addr);
        continue;
      end
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o.sig !== e.sig || o.addr !== e.addr || o.dt !== e.dt || o.has_x) begin
        tests_failed++;
        $display("FAIL fill_beat%0d: got sig=%h addr=%h expected sig=%h addr=%h",
                 b, o.sig, o.addr, e.sig, e.addr);
      end
    end
    r  = resp_q.pop_front();
    el = exp_resp_q.pop_front();
    tests_run++;
    if (r.line !== el || r.line[31:0] !== 32'h11223344 || r.line[127:96] !== 32'hDDEEFF00) begin
      tests_failed++;
      $display("FAIL fill_line: got %h expected %h", r.line, el);
    end
    tests_run++;
    if (r.cyc - e0 !== 16) begin
      tests_failed++;
      $display("FAIL fill_latency: got %0d expected 16", r.cyc - e0);
    end
  endtask

  task automatic test_writeback();
    bit ok;
    beat_t o, e;
    resp_t r;
    logic [LINEW-1:0] wd, el;
    wd = {$urandom, $urandom, $urandom, 32'hDEADBEEF};
    start_op(1'b1, AW'(32'h200), wd, 1'b0);
    wait_resp(1, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL wb_timeout: got no resp_valid expected one");
      return;
    end
    for (int b = 0; b < LW; b++) begin
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++;
        $display("FAIL wb_beat%0d: got no beat expected a write", b);
        continue;
      end
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o.sig !== e.sig || o.addr !== e.addr || o.wdata !== e.wdata || o.dt !== e.dt) begin
        tests_failed++;
        $display("FAIL wb_beat%0d: got sig=%h addr=%h wd=%h dt=%h expected %h %h %h %h",
                 b, o.sig, o.addr, o.wdata, o.dt, e.sig, e.addr, e.wdata, e.dt);
      end
    end
    r  = resp_q.pop_front();
    el = exp_resp_q.pop_front();
    tests_run++;
    if (r.line !== el) begin
      tests_failed++;
      $display("FAIL wb_rdata_held: got %h expected %h", r.line, el);
    end
    tests_run++;
    if ({mem[AW'(32'h200)], mem[AW'(32'h201)], mem[AW'(32'h202)], mem[AW'(32'h203)]}
        !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL wb_mem_bytes: got %h%h%h%h expected deadbeef", mem[AW'(32'h200)],
               mem[AW'(32'h201)], mem[AW'(32'h202)], mem[AW'(32'h203)]);
    end
    start_op(1'b0, AW'(32'h200), '0, 1'b0);
    wait_resp(1, ok);
    void'(exp_resp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL wb_readback: got no resp_valid expected one");
    end else begin
      r = resp_q.pop_front();
      if (r.line !== wd) begin
        tests_failed++;
        $display("FAIL wb_readback: got %h expected %h", r.line, wd);
      end
    end
  endtask

  task automatic test_icache_contention();
    bit ok;
    int guard;
    resp_t r;
    logic [LINEW-1:0] el;
    start_op(1'b0, AW'(32'h300), '0, 1'b0);
    guard = 0;
    while (obs_q.size() < 2 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    ic_sig = MEM_READ;
    repeat (6) @(negedge clk);
    #1;
    tests_run++;
    if (obs_q.size() !== 2 || mem_status !== MEM_INST_FINISHED) begin
      tests_failed++;
      $display("FAIL ic_stall: got beats=%0d status=%h expected 2/%h", obs_q.size(), mem_status,
               MEM_INST_FINISHED);
    end
    ic_sig = MEM_NOP;
    wait_resp(1, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL ic_timeout: got no resp_valid expected one");
      return;
    end
    tests_run++;
    if (obs_q.size() !== 4 || obs_q[1].addr !== AW'(32'h304) || obs_q[3].addr !== AW'(32'h30C)) begin
      tests_failed++;
      $display("FAIL ic_beats: got %0d beats expected 4 at 300..30c", obs_q.size());
    end
    obs_q.delete();
    exp_q.delete();
    r  = resp_q.pop_front();
    el = exp_resp_q.pop_front();
    tests_run++;
    if (r.line !== el) begin
      tests_failed++;
      $display("FAIL ic_line: got %h expected %h", r.line, el);
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    int guard;
    resp_t r;
    logic [LINEW-1:0] el;
    start_op(1'b0, AW'(32'h400), '0, 1'b0);
    guard = 0;
    while (obs_q.size() < 3 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (dsig !== MEM_NOP || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_async: got sig=%h rv=%b expected %h/0", dsig, resp_valid, MEM_NOP);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || resp_rdata !== '0) begin
      tests_failed++;
      $display("FAIL midreset_ready: got rdy=%b rdata=%h expected 1/0", req_ready, resp_rdata);
    end
    repeat (10) @(negedge clk);
    #1;
    tests_run++;
    if (resp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL midreset_noresp: got %0d responses expected 0", resp_q.size());
    end
    resp_q.delete();
    obs_q.delete();
    exp_q.delete();
    exp_resp_q.delete();
    last_fill = '0;
    start_op(1'b0, AW'(32'h100), '0, 1'b0);
    wait_resp(1, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL midreset_refill: got no resp_valid expected one");
      return;
    end
    obs_q.delete();
    exp_q.delete();
    r  = resp_q.pop_front();
    el = exp_resp_q.pop_front();
    if (r.line !== el) begin
      tests_failed++;
      $display("FAIL midreset_refill: got %h expected %h", r.line, el);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int guard;
    beat_t o, e;
    resp_t r;
    logic [LINEW-1:0] el;
    start_op(1'b0, AW'(32'h500), '0, 1'b1);
    req_addr = AW'(32'h600);
    for (int b = 0; b < LW; b++) begin
      exp_q.push_back('{MEM_READ, AW'(32'h600 + 4 * b), '0, FOUR_BYTE, 0, 1'b0});
    end
    wait_resp(1, ok);
    tests_run++;
    if (!ok || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first: got ok=%b rdy=%b expected 1/0", ok, req_ready);
    end
    last_fill = line_at(AW'(32'h600));
    exp_resp_q.push_back(last_fill);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(2, ok);
    tests_run++;
    if (!ok || obs_q.size() !== 8) begin
      tests_failed++;
      $display("FAIL b2b_second: got resp=%0d beats=%0d expected 2/8", resp_q.size(), obs_q.size());
      obs_q.delete();
      exp_q.delete();
      resp_q.delete();
      exp_resp_q.delete();
      return;
    end
    tests_run++;
    if (obs_q[4].nop_run < 2) begin
      tests_failed++;
      $display("FAIL b2b_nop_gap: got %0d expected >= 2", obs_q[4].nop_run);
    end
    for (int b = 0; b < 2 * LW; b++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o.sig !== e.sig || o.addr !== e.addr) begin
        tests_failed++;
        $display("FAIL b2b_beat%0d: got %h/%h expected %h/%h", b, o.sig, o.addr, e.sig, e.addr);
      end
    end
    for (int k = 0; k < 2; k++) begin
      r  = resp_q.pop_front();
      el = exp_resp_q.pop_front();
      tests_run++;
      if (r.line !== el) begin
        tests_failed++;
        $display("FAIL b2b_line%0d: got %h expected %h", k, r.line, el);
      end
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    beat_t o, e;
    resp_t r;
    logic [LINEW-1:0] el;
    start_op(1'b0, AW'(32'h1FFF0), '0, 1'b0);
    wait_resp(1, ok);
    tests_run++;
    if (!ok || obs_q.size() !== 4) begin
      tests_failed++;
      $display("FAIL wrap_timeout: got resp=%0d beats=%0d expected 1/4", resp_q.size(), obs_q.size());
      return;
    end
    for (int b = 0; b < LW; b++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o.addr !== e.addr || o.has_x) begin
        tests_failed++;
        $display("FAIL wrap_beat%0d: got addr=%h x=%b expected %h/0", b, o.addr, o.has_x, e.addr);
      end
    end
    r  = resp_q.pop_front();
    el = exp_resp_q.pop_front();
    tests_run++;
    if (r.line !== el || $isunknown(r.line)) begin
      tests_failed++;
      $display("FAIL wrap_line: got %h expected %h", r.line, el);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    test_reset();
    test_fill();
    test_writeback();
    test_icache_contention();
    test_reset_mid_op();
    test_back_to_back();
    test_addr_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dcache_mem_initiator.md
Name: dcache_mem_initiator

Overview:
Memory-side initiator for the data cache. It takes one cache-line fill or writeback request, splits it into 4-byte beats on the data port of the main memory, and assembles read beats into a line. It owns the d_cache_mem_vis_* request signals and consumes mem_data and mem_status. Each beat is a full handshake: request, wait for completion, drop to NOP, then wait for the memory to return to resting. This prevents a held request from being re-executed or having its stale status misread.

Parameters:
ADDR_WIDTH, 17, memory byte-address width
DATA_LEN, 32, memory data bus width (one beat)
LINE_WORDS, 4, beats per cache line (power of two, at least 1)
ENTRY_INDEX_SIZE, 3, width-1 of the length field driven to memory

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  cache requests a line operation
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready at posedge
req_write  in  1  1 = writeback, 0 = fill
req_addr  in  ADDR_WIDTH  line base byte address; low log2(LINE_WORDS*4) bits ignored (forced 0)
req_wdata  in  LINE_WORDS*DATA_LEN  writeback line; word i in bits [32i+31:32i]
resp_valid  out  1  one-cycle pulse when the operation is complete
resp_rdata  out  LINE_WORDS*DATA_LEN  filled line, same word layout; held until next fill completes
d_cache_mem_vis_signal  out  2  MEM_NOP / MEM_READ / MEM_WRITE
d_cache_mem_vis_addr  out  ADDR_WIDTH  beat byte address = base + 4*beat
written_data  out  DATA_LEN  beat write word
data_type  out  3  always FOUR_BYTE
length  out  ENTRY_INDEX_SIZE+1  LINE_WORDS (informational)
mem_data  in  DATA_LEN  memory read word; byte at addr in [31:24] (big-endian beat order)
mem_status  in  2  MEM_RESTING / MEM_DATA_FINISHED / MEM_INST_FINISHED

Behaviour:
- Reset (async, rst_n=0): state IDLE, beat counter 0, d_cache_mem_vis_signal=MEM_NOP, addr=0, written_data=0, resp_valid=0, resp_rdata=0. Reset mid-operation abandons the beat; the signal goes to MEM_NOP immediately and no resp_valid is produced.
- All outputs are registered from state except req_ready (state==IDLE) and the constant data_type/length.
- States:
  - IDLE: on accept, latch base, write line, and op. Set beat=0 and go to ISSUE.
  - ISSUE: drive MEM_READ or MEM_WRITE, the beat address, and the beat word. Wait for mem_status==MEM_DATA_FINISHED.
    - MEM_INST_FINISHED and MEM_RESTING are ignored. The memory serves the instruction cache first on reads, so a data read stalls while I-cache traffic is active.
    - On MEM_DATA_FINISHED for a read, capture mem_data into word[beat]. Then go to GAP with the signal set to MEM_NOP.
  - GAP: drive MEM_NOP and wait for mem_status==MEM_RESTING.
    - If beat==LINE_WORDS-1, go to DONE; otherwise increment beat and go to ISSUE.
  - DONE: resp_valid=1 for exactly one cycle, then IDLE.
- GAP always follows the last beat, so the next request never sees a leftover FINISHED status.
- Uncontended timing: 4 clock edges per beat. A 4-beat operation accepted at edge E0 raises resp_valid in the cycle after edge E0+16.
- Beat addresses wrap modulo 2^ADDR_WIDTH; there is no error reporting.
- req_valid is ignored outside IDLE. Request inputs need not be held after acceptance.

Decomposition:
- MEM_NOP/READ/WRITE, MEM_RESTING/DATA_FINISHED/INST_FINISHED and ONE/TWO/FOUR/EIGHT_BYTE encodings stay in the shared defines file.
- State encodings are local to this block.
- No sub-module: the line assembly register and beat mux are inline.

Test Plan:
- Fill, memory bytes 0x100..0x10F = 11 22 .. FF 00, I-cache idle, req_addr=0x104 -> addresses 0x100, 0x104, 0x108, 0x10C. resp_rdata word0=0x11223344 and word3=0xDDEEFF00. resp_valid lands 16 cycles after accept.
- Writeback to 0x200 with word0=0xDEADBEEF -> four MEM_WRITE beats, data_type=FOUR_BYTE. Memory bytes 0x200..0x203 = DE AD BE EF; a later fill returns an identical line.
- Fill while I-cache issues MEM_READ for 6 cycles during beat 1 -> MEM_INST_FINISHED is ignored, beat 1 completes after I-cache drops, and data is correct.
- rst_n pulsed low during beat 2 of a fill -> signal goes to MEM_NOP asynchronously, no resp_valid, req_ready=1 after release. A following fill completes correctly.
- Back-to-back: req_valid held high with two fills -> second accepted only in IDLE after DONE. Signal is MEM_NOP for at least 2 cycles between the operations.
- Address wrap: fill at 0x1FFF0 with ADDR_WIDTH=17 -> beat addresses 0x1FFF0..0x1FFFC, no X on outputs.
